ip4_rtl_opc: RTL
================

IP4_RTL_OPC -- requirements
Module: ip4_rtl_opc

Interface
REQ-001 SHALL have parameter WORD_W, default 32, operand/data width.
REQ-002 SHALL have parameter REG_AW, default 6, register-file address width.
REQ-003 SHALL have parameter OPC_W, default 8, opcode width.
REQ-004 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_vld  input  1  upstream instruction valid.
REQ-007 SHALL have port in_rdy  output  1  collector can accept an instruction.
REQ-008 SHALL have port in_opc  input  OPC_W  opcode passed to the stream processor array.
REQ-009 SHALL have ports in_ra0..in_ra3  input  REG_AW each  source register addresses.
REQ-010 SHALL have port in_nsrc  input  3  number of source operands, 0..4.
REQ-011 SHALL have ports rf_re0, rf_re1  output  1 each  register-file read enables.
REQ-012 SHALL have ports rf_ra0, rf_ra1  output  REG_AW each  register-file read addresses.
REQ-013 SHALL have ports rf_rd0, rf_rd1  input  WORD_W each  read data, valid exactly 1 cycle after the matching re.
REQ-014 SHALL have port out_vld  output  1  collected operand bundle valid to the stream processor array.
REQ-015 SHALL have port out_rdy  input  1  stream processor array accepts the bundle.
REQ-016 SHALL have port out_opc  output  OPC_W  registered opcode.
REQ-017 SHALL have ports out_op0..out_op3  output  WORD_W each  collected operands op0..op3.

Function
REQ-018 SHALL implement FSM states IDLE, RD01, RD23, CAP, ISSUE.
REQ-019 SHALL drive in_rdy=1 only in IDLE; an accept is in_vld&&in_rdy, which latches in_opc, in_ra0..3 and in_nsrc.
REQ-020 SHALL clamp in_nsrc values 5..7 to 4 at accept.
REQ-021 SHALL transition on accept: nsrc=0 -> ISSUE; nsrc>=1 -> RD01.
REQ-022 RD01: rf_re0=1, rf_ra0=ra0; rf_re1=(nsrc>=2), rf_ra1=ra1; next state RD23 if nsrc>=3, else CAP.
REQ-023 RD23: capture rf_rd0 -> op0 and rf_rd1 -> op1 (op1 only if nsrc>=2); rf_re0=1, rf_ra0=ra2; rf_re1=(nsrc=4), rf_ra1=ra3; next CAP.
REQ-024 CAP: capture the pair read in the previous cycle (op0/op1 if coming from RD01, op2/op3 if from RD23), per nsrc; next ISSUE.
REQ-025 Operands with index >= nsrc SHALL be 0 in the issued bundle; a register cleared at accept satisfies this.
REQ-026 ISSUE: out_vld=1; out_opc/out_op0..3 SHALL stay stable while out_vld&&!out_rdy.
REQ-027 ISSUE with out_rdy=1 SHALL return to IDLE next cycle; no back-to-back accept in the handshake cycle.
REQ-028 Latency, accept cycle T to first out_vld: nsrc=0 -> T+1; nsrc=1..2 -> T+3; nsrc=3..4 -> T+4.
REQ-029 rf_re0/rf_re1 SHALL be 0 in IDLE, CAP and ISSUE; rf_ra0/rf_ra1 are don't-care when the matching re is 0 but SHALL NOT be X.
REQ-030 in_vld asserted in any non-IDLE state SHALL be ignored; upstream holds it because in_rdy=0.
REQ-031 out_rdy asserted while out_vld=0 SHALL have no effect.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, out_vld=0, out_opc=0, out_op0..3=0, rf_re0=rf_re1=0, rf_ra0=rf_ra1=0, and all latched fields to 0.
REQ-033 After rst deasserts, in_rdy SHALL be 1 in the first cycle.
REQ-034 rst asserted mid-operation (any state) SHALL abandon the instruction; no out_vld SHALL follow for it, and read data returning after reset SHALL be ignored.

Verification
REQ-035 nsrc=2, ra0=3, ra1=7, RF holds rN=N*0x11 -> out_vld at T+3, op0=0x33, op1=0x77, op2=op3=0.
REQ-036 nsrc=4, ra0..3=1,2,3,4 -> re pattern RD01(1,2), RD23(3,4); out_vld at T+4, ops 0x11,0x22,0x33,0x44.
REQ-037 nsrc=0, opc=0x5A -> out_vld at T+1, out_opc=0x5A, all ops 0, no rf_re pulses.
REQ-038 nsrc=3 with out_rdy held 0 for 5 cycles -> bundle stable (op3=0) for all 5 cycles; in_rdy=1 the cycle after the out_rdy handshake.
REQ-039 nsrc=7 -> treated as 4; rst pulsed in RD23 -> outputs 0, state IDLE, no out_vld afterwards.

Source files
------------

// File: rtl/ip4_rtl_opc.sv
//------------------------------------------------------------------------------
// ip4_rtl_opc: operand collector. Accepts one instruction, fetches up to four
// source operands over two register-file read ports, issues the bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ip4_rtl_opc #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 6,
  parameter int OPC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [OPC_W-1:0]  in_opc,
  input  logic [REG_AW-1:0] in_ra0,
  input  logic [REG_AW-1:0] in_ra1,
  input  logic [REG_AW-1:0] in_ra2,
  input  logic [REG_AW-1:0] in_ra3,
  input  logic [2:0]        in_nsrc,
  output logic              rf_re0,
  output logic              rf_re1,
  output logic [REG_AW-1:0] rf_ra0,
  output logic [REG_AW-1:0] rf_ra1,
  input  logic [WORD_W-1:0] rf_rd0,
  input  logic [WORD_W-1:0] rf_rd1,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [OPC_W-1:0]  out_opc,
  output logic [WORD_W-1:0] out_op0,
  output logic [WORD_W-1:0] out_op1,
  output logic [WORD_W-1:0] out_op2,
  output logic [WORD_W-1:0] out_op3
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD01  = 3'd1,
    RD23  = 3'd2,
    CAP   = 3'd3,
    ISSUE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] ra0, ra1, ra2, ra3;
  logic [2:0]        nsrc;
  logic              accept;

  assign accept  = in_vld && in_rdy;
  assign out_opc = opc;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    rf_re0    = 1'b0;
    rf_re1    = 1'b0;
    rf_ra0    = ra0;
    rf_ra1    = ra1;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = (in_nsrc == 3'd0) ? ISSUE : RD01;
      end
      RD01: begin
        rf_re0    = 1'b1;
        rf_re1    = (nsrc >= 3'd2);
        state_nxt = (nsrc >= 3'd3) ? RD23 : CAP;
      end
      RD23: begin
        rf_re0    = 1'b1;
        rf_ra0    = ra2;
        rf_re1    = (nsrc == 3'd4);
        rf_ra1    = ra3;
        state_nxt = CAP;
      end
      CAP: state_nxt = ISSUE;
      ISSUE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are cleared at accept so unused slots issue as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc     <= '0;
      ra0     <= '0;
      ra1     <= '0;
      ra2     <= '0;
      ra3     <= '0;
      nsrc    <= '0;
      out_op0 <= '0;
      out_op1 <= '0;
      out_op2 <= '0;
      out_op3 <= '0;
    end else if (accept) begin
      opc     <= in_opc;
      ra0     <= in_ra0;
      ra1     <= in_ra1;
      ra2     <= in_ra2;
      ra3     <= in_ra3;
      nsrc    <= (in_nsrc > 3'd4) ? 3'd4 : in_nsrc;
      out_op0 <= '0;
      out_op1 <= '0;
      out_op2 <= '0;
      out_op3 <= '0;
    end else begin
      case (state)
        RD23: begin
          out_op0 <= rf_rd0;
          if (nsrc >= 3'd2) out_op1 <= rf_rd1;
        end
        // nsrc >= 3 implies the previous cycle was RD23 (reading ra2/ra3).
        CAP: begin
          if (nsrc >= 3'd3) begin
            out_op2 <= rf_rd0;
            if (nsrc == 3'd4) out_op3 <= rf_rd1;
          end else begin
            out_op0 <= rf_rd0;
            if (nsrc >= 3'd2) out_op1 <= rf_rd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
